// File: rtl/dac_serializer.sv
// rtl/dac_serializer.sv - Fixed-point sample to saturated two's-complement word, shifted MSB first to a SPI-style DAC.
module dac_serializer #(
  parameter int CLKDIV  = 4,
  parameter int FPSHIFT = 28,
  parameter int OUTBITS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] sinevalue,
  input  logic        sample_strobe,
  output logic        dac_cs_n,
  output logic        dac_sclk,
  output logic        dac_sdata,
  output logic        busy,
  output logic        overrun
);

  localparam int SHIFT = FPSHIFT - OUTBITS + 1;
  localparam int DIVW  = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam int BITW  = $clog2(OUTBITS);
  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(CLKDIV - 1);
  localparam logic [BITW-1:0] BIT_LAST = BITW'(OUTBITS - 1);
  localparam logic signed [31:0] SAT_HI = {{(33-OUTBITS){1'b0}}, {(OUTBITS-1){1'b1}}};
  localparam logic signed [31:0] SAT_LO = {{(33-OUTBITS){1'b1}}, {(OUTBITS-1){1'b0}}};
  localparam logic [OUTBITS-1:0] WORD_HI = {1'b0, {(OUTBITS-1){1'b1}}};
  localparam logic [OUTBITS-1:0] WORD_LO = {1'b1, {(OUTBITS-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

  state_t             state_q, state_d;
  logic [OUTBITS-1:0] shreg_q, shreg_d;
  logic [DIVW-1:0]    div_q, div_d;
  logic [BITW-1:0]    bit_q, bit_d;
  logic               cs_n_q, cs_n_d;
  logic               sclk_q, sclk_d;
  logic               busy_q, busy_d;
  logic               ovr_q, ovr_d;

  logic signed [31:0] scaled;
  logic [OUTBITS-1:0] word;

  // Arithmetic shift floors toward minus infinity; out-of-range results clamp.
  always_comb begin
    scaled = $signed(sinevalue) >>> SHIFT;
    if (scaled > SAT_HI)      word = WORD_HI;
    else if (scaled < SAT_LO) word = WORD_LO;
    else                      word = scaled[OUTBITS-1:0];
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    div_d   = div_q;
    bit_d   = bit_q;
    cs_n_d  = cs_n_q;
    sclk_d  = sclk_q;
    busy_d  = busy_q;
    ovr_d   = sample_strobe && busy_q;
    case (state_q)
      S_IDLE: begin
        if (sample_strobe && !busy_q) begin
          shreg_d = word;
          div_d   = '0;
          bit_d   = '0;
          cs_n_d  = 1'b0;
          sclk_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            // Zero fill leaves dac_sdata low once the last bit has gone out.
            sclk_d  = 1'b0;
            shreg_d = {shreg_q[OUTBITS-2:0], 1'b0};
            if (bit_q == BIT_LAST) begin
              cs_n_d  = 1'b1;
              state_d = S_GAP;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_GAP: begin
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      cs_n_q  <= cs_n_d;
      sclk_q  <= sclk_d;
      busy_q  <= busy_d;
      ovr_q   <= ovr_d;
    end
  end

  assign dac_cs_n  = cs_n_q;
  assign dac_sclk  = sclk_q;
  assign dac_sdata = shreg_q[OUTBITS-1];
  assign busy      = busy_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_dac_serializer.sv
// tb/tb_dac_serializer.sv - Scoreboard bench for dac_serializer at CLKDIV=4 and CLKDIV=1.
module tb_dac_serializer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] sine4 = 32'h0, sine1 = 32'h0;
  logic        stb4 = 1'b0, stb1 = 1'b0;
  logic        cs4, sclk4, sdata4, busy4, ovr4;
  logic        cs1, sclk1, sdata1, busy1, ovr1;

  int total = 0;
  int bad = 0;
  logic [15:0] exp4[$];
  logic [15:0] exp1[$];

  always #5 clk = ~clk;

  dac_serializer #(.CLKDIV(4), .FPSHIFT(28), .OUTBITS(16)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .sinevalue(sine4), .sample_strobe(stb4),
    .dac_cs_n(cs4), .dac_sclk(sclk4), .dac_sdata(sdata4), .busy(busy4), .overrun(ovr4)
  );

  dac_serializer #(.CLKDIV(1), .FPSHIFT(28), .OUTBITS(16)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .sinevalue(sine1), .sample_strobe(stb1),
    .dac_cs_n(cs1), .dac_sclk(sclk1), .dac_sdata(sdata1), .busy(busy1), .overrun(ovr1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Frame monitor for the CLKDIV=4 instance.
  logic [15:0] m4_word = 16'h0;
  int          m4_bits, m4_cs, m4_busy;
  logic        m4_psclk, m4_pcs, m4_pbusy;
  always @(negedge clk) begin
    if (!rst_n) begin
      m4_bits = 0; m4_cs = 0; m4_busy = 0;
      m4_psclk = 1'b0; m4_pcs = 1'b1; m4_pbusy = 1'b0;
    end else begin
      if (!cs4) m4_cs++;
      if (busy4) m4_busy++;
      if (sclk4 && !m4_psclk) begin
        m4_word = {m4_word[14:0], sdata4};
        m4_bits++;
      end
      if (cs4 && !m4_pcs) begin
        chk("d4 sclk rises", m4_bits, 16);
        chk("d4 cs_n low cycles", m4_cs, 128);
        chk("d4 frame expected", 32'(exp4.size() > 0), 1);
        if (exp4.size() > 0) chk("d4 word", 32'(m4_word), 32'(exp4.pop_front()));
        m4_bits = 0; m4_cs = 0;
      end
      if (!busy4 && m4_pbusy) begin
        chk("d4 busy cycles", m4_busy, 132);
        m4_busy = 0;
      end
      m4_psclk = sclk4; m4_pcs = cs4; m4_pbusy = busy4;
    end
  end

  // Frame monitor for the CLKDIV=1 instance.
  logic [15:0] m1_word = 16'h0;
  int          m1_bits, m1_cs, m1_busy;
  logic        m1_psclk, m1_pcs, m1_pbusy;
  always @(negedge clk) begin
    if (!rst_n) begin
      m1_bits = 0; m1_cs = 0; m1_busy = 0;
      m1_psclk = 1'b0; m1_pcs = 1'b1; m1_pbusy = 1'b0;
    end else begin
      if (!cs1) m1_cs++;
      if (busy1) m1_busy++;
      if (sclk1 && !m1_psclk) begin
        m1_word = {m1_word[14:0], sdata1};
        m1_bits++;
      end
      if (cs1 && !m1_pcs) begin
        chk("d1 sclk rises", m1_bits, 16);
        chk("d1 cs_n low cycles", m1_cs, 32);
        chk("d1 frame expected", 32'(exp1.size() > 0), 1);
        if (exp1.size() > 0) chk("d1 word", 32'(m1_word), 32'(exp1.pop_front()));
        m1_bits = 0; m1_cs = 0;
      end
      if (!busy1 && m1_pbusy) begin
        chk("d1 busy cycles", m1_busy, 33);
        m1_busy = 0;
      end
      m1_psclk = sclk1; m1_pcs = cs1; m1_pbusy = busy1;
    end
  end

  // Returns just after the accepting edge; sinevalue is then scrambled.
  task automatic send4(input logic [31:0] v, input logic [15:0] w, input bit push);
    @(posedge clk); #1;
    sine4 = v; stb4 = 1'b1;
    @(posedge clk); #1;
    stb4 = 1'b0; sine4 = ~v;
    if (push) exp4.push_back(w);
  endtask

  task automatic send1(input logic [31:0] v, input logic [15:0] w);
    @(posedge clk); #1;
    sine1 = v; stb1 = 1'b1;
    @(posedge clk); #1;
    stb1 = 1'b0; sine1 = ~v;
    exp1.push_back(w);
  endtask

  task automatic wait_idle(input int which);
    int n = 0;
    @(negedge clk);
    while (((which == 4) ? busy4 : busy1) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if ((which == 4) ? busy4 : busy1) chk("idle timeout", 32'(which), 0);
  endtask

  logic [31:0] vals[5]  = '{32'h10000000, 32'hE8000000, 32'hF0000000, 32'h00001FFF, 32'hFFFFFFFF};
  logic [15:0] words[5] = '{16'h7FFF, 16'h8000, 16'h8000, 16'h0000, 16'hFFFF};

  initial begin
    stb4 = 1'b1;
    sine4 = 32'h08000000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset cs_n", 32'(cs4), 1);
    chk("reset sclk", 32'(sclk4), 0);
    chk("reset sdata", 32'(sdata4), 0);
    chk("reset busy", 32'(busy4), 0);
    chk("reset overrun", 32'(ovr4), 0);
    chk("reset d1 cs_n", 32'(cs1), 1);

    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    stb4 = 1'b0; sine4 = 32'h12345678;
    exp4.push_back(16'h4000);
    @(negedge clk);
    chk("first strobe cs_n", 32'(cs4), 0);
    chk("first strobe busy", 32'(busy4), 1);
    wait_idle(4);

    for (int i = 0; i < 5; i++) begin
      send4(vals[i], words[i], 1'b1);
      wait_idle(4);
    end

    send4(32'h08000000, 16'h4000, 1'b1);
    repeat (49) @(posedge clk);
    #1; stb4 = 1'b1; sine4 = 32'h10000000;
    @(posedge clk); #1;
    stb4 = 1'b0;
    @(negedge clk);
    chk("overrun pulse", 32'(ovr4), 1);
    chk("busy during overrun", 32'(busy4), 1);
    @(negedge clk);
    chk("overrun one cycle", 32'(ovr4), 0);
    repeat (80) @(posedge clk);
    #1; stb4 = 1'b1; sine4 = 32'h0AAAAAAA;
    @(posedge clk); #1;
    @(negedge clk);
    chk("last gap overrun", 32'(ovr4), 1);
    chk("busy drop", 32'(busy4), 0);
    @(posedge clk); #1;
    stb4 = 1'b0; sine4 = 32'h0;
    exp4.push_back(16'h5555);
    @(negedge clk);
    chk("back to back cs_n", 32'(cs4), 0);
    wait_idle(4);

    send4(32'h10000000, 16'h0, 1'b0);
    repeat (39) @(posedge clk);
    #1; rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort cs_n", 32'(cs4), 1);
    chk("abort sclk", 32'(sclk4), 0);
    chk("abort busy", 32'(busy4), 0);
    repeat (200) @(posedge clk);
    @(negedge clk);
    chk("abort stays idle", 32'(busy4), 0);
    send4(32'h08000000, 16'h4000, 1'b1);
    wait_idle(4);

    send1(32'h0AAAAAAA, 16'h5555);
    wait_idle(1);
    send1(32'h10000000, 16'h7FFF);
    wait_idle(1);

    repeat (5) @(negedge clk);
    chk("d4 frames outstanding", 32'(exp4.size()), 0);
    chk("d1 frames outstanding", 32'(exp1.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
